// File: rtl/id_ex_operand_stage_if.sv
// Decode/forwarding/ALU-side bundle for the ID/EX operand stage.
// Member names match the legacy flat ports so existing connections map one-to-one.
interface id_ex_operand_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
);
  logic            i_hold;
  logic            i_flush;
  logic            i_id_valid;
  logic [XLEN-1:0] i_id_pc;
  logic [XLEN-1:0] i_id_rs1_data;
  logic [XLEN-1:0] i_id_rs2_data;
  logic [XLEN-1:0] i_id_imm;
  logic [RA_W-1:0] i_id_rs1_addr;
  logic [RA_W-1:0] i_id_rs2_addr;
  logic [RA_W-1:0] i_id_rd_addr;
  logic            i_id_rd_wren;
  logic            i_id_opa_sel;
  logic            i_id_opb_sel;
  logic [3:0]      i_id_alu_op;
  logic [RA_W-1:0] i_mem_rd_addr;
  logic            i_mem_rd_wren;
  logic [XLEN-1:0] i_mem_fwd_data;
  logic [RA_W-1:0] i_wb_rd_addr;
  logic            i_wb_rd_wren;
  logic [XLEN-1:0] i_wb_data;
  logic [XLEN-1:0] o_operand_a;
  logic [XLEN-1:0] o_operand_b;
  logic [3:0]      o_alu_op;
  logic [XLEN-1:0] o_store_data;
  logic [XLEN-1:0] o_pc;
  logic [RA_W-1:0] o_rd_addr;
  logic            o_rd_wren;
  logic            o_valid;

  modport master (
    output i_hold, i_flush, i_id_valid, i_id_pc, i_id_rs1_data, i_id_rs2_data,
           i_id_imm, i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr, i_id_rd_wren,
           i_id_opa_sel, i_id_opb_sel, i_id_alu_op,
           i_mem_rd_addr, i_mem_rd_wren, i_mem_fwd_data,
           i_wb_rd_addr, i_wb_rd_wren, i_wb_data,
    input  o_operand_a, o_operand_b, o_alu_op, o_store_data, o_pc,
           o_rd_addr, o_rd_wren, o_valid
  );

  modport slave (
    input  i_hold, i_flush, i_id_valid, i_id_pc, i_id_rs1_data, i_id_rs2_data,
           i_id_imm, i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr, i_id_rd_wren,
           i_id_opa_sel, i_id_opb_sel, i_id_alu_op,
           i_mem_rd_addr, i_mem_rd_wren, i_mem_fwd_data,
           i_wb_rd_addr, i_wb_rd_wren, i_wb_data,
    output o_operand_a, o_operand_b, o_alu_op, o_store_data, o_pc,
           o_rd_addr, o_rd_wren, o_valid
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and ALU operand selection.
// Hold keeps contents but refreshes stored rs data from WB so a retired writer is not lost.
module id_ex_operand_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input logic                 i_clk,
  input logic                 i_reset,
  id_ex_operand_stage_if.slave bus
);

  localparam logic [3:0] ALU_ADD = 4'b0000;

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic [RA_W-1:0] rs1_addr_q;
  logic [RA_W-1:0] rs2_addr_q;
  logic [RA_W-1:0] rd_addr_q;
  logic            rd_wren_q;
  logic            opa_sel_q;
  logic            opb_sel_q;
  logic [3:0]      alu_op_q;

  logic            wb_hit_rs1;
  logic            wb_hit_rs2;
  logic            mem_hit_rs1;
  logic            mem_hit_rs2;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // Hit detection against the stored (registered) source addresses; x0 never matches.
  always_comb begin
    mem_hit_rs1 = bus.i_mem_rd_wren && (bus.i_mem_rd_addr == rs1_addr_q) && (rs1_addr_q != '0);
    mem_hit_rs2 = bus.i_mem_rd_wren && (bus.i_mem_rd_addr == rs2_addr_q) && (rs2_addr_q != '0);
    wb_hit_rs1  = bus.i_wb_rd_wren  && (bus.i_wb_rd_addr  == rs1_addr_q) && (rs1_addr_q != '0);
    wb_hit_rs2  = bus.i_wb_rd_wren  && (bus.i_wb_rd_addr  == rs2_addr_q) && (rs2_addr_q != '0);
  end

  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (mem_hit_rs1)
      fwd_rs1 = bus.i_mem_fwd_data;
    else if (wb_hit_rs1)
      fwd_rs1 = bus.i_wb_data;

    fwd_rs2 = rs2_data_q;
    if (mem_hit_rs2)
      fwd_rs2 = bus.i_mem_fwd_data;
    else if (wb_hit_rs2)
      fwd_rs2 = bus.i_wb_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      rd_wren_q  <= 1'b0;
      opa_sel_q  <= 1'b0;
      opb_sel_q  <= 1'b0;
      alu_op_q   <= ALU_ADD;
    end else if (bus.i_flush) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      rd_wren_q  <= 1'b0;
      opa_sel_q  <= 1'b0;
      opb_sel_q  <= 1'b0;
      alu_op_q   <= ALU_ADD;
    end else if (bus.i_hold) begin
      if (wb_hit_rs1)
        rs1_data_q <= bus.i_wb_data;
      if (wb_hit_rs2)
        rs2_data_q <= bus.i_wb_data;
    end else begin
      valid_q    <= bus.i_id_valid;
      pc_q       <= bus.i_id_pc;
      rs1_data_q <= bus.i_id_rs1_data;
      rs2_data_q <= bus.i_id_rs2_data;
      imm_q      <= bus.i_id_imm;
      rs1_addr_q <= bus.i_id_rs1_addr;
      rs2_addr_q <= bus.i_id_rs2_addr;
      rd_addr_q  <= bus.i_id_rd_addr;
      rd_wren_q  <= bus.i_id_rd_wren & bus.i_id_valid;
      opa_sel_q  <= bus.i_id_opa_sel;
      opb_sel_q  <= bus.i_id_opb_sel;
      alu_op_q   <= bus.i_id_alu_op;
    end
  end

  always_comb begin
    bus.o_operand_a  = opa_sel_q ? pc_q  : fwd_rs1;
    bus.o_operand_b  = opb_sel_q ? imm_q : fwd_rs2;
    bus.o_store_data = fwd_rs2;
    bus.o_alu_op     = alu_op_q;
    bus.o_pc         = pc_q;
    bus.o_rd_addr    = rd_addr_q;
    bus.o_rd_wren    = rd_wren_q;
    bus.o_valid      = valid_q;
  end

endmodule
